uart_tx_fifo: RTL and testbench

UART transmitter with a small byte FIFO on its input side. It serialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at CLKS_PER_BIT clocks per bit. It sits between on-chip byte producers and the serial TX pin, and is the transmit-side counterpart to the team's UART receiver using the same bit timing. The FIFO lets producers queue bursts without tracking line timing.

---
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a small circular byte FIFO
//
// Ports:
//   i_Clock       rising-edge clock for all logic
//   i_Reset       synchronous active-high reset
//   i_Tx_DV       write strobe; byte taken when i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte     byte to queue
//   o_Tx_Ready    FIFO not full
//   o_Tx_Overflow one-cycle pulse after a write that arrived while full (byte dropped)
//   o_Fifo_Count  bytes waiting in the FIFO, excluding the byte on the line
//   o_Tx_Serial   serial line, idles high
//   o_Tx_Active   high while start, data or stop bits are on the line
//   o_Tx_Done     one-cycle pulse in the cycle after the last stop-bit cycle
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic                        o_Tx_Overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done
);

  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0]    LAST_CLK  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]    FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]    ONE       = (AW + 1)'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } state_t;

  // FIFO storage
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Transmit datapath
  state_t      state, state_n;
  logic [15:0] clk_cnt, clk_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        serial_n, active_n, done_n;

  logic push;
  logic pop;
  logic bit_end;

  assign o_Tx_Ready   = (count != FULL);
  assign o_Fifo_Count = count;

  // Ready is evaluated before the pop, so a write while full is dropped
  // even when the FSM frees a slot in the same cycle.
  assign push    = i_Tx_DV && o_Tx_Ready && !i_Reset;
  assign pop     = (state == IDLE) && (count != '0);
  assign bit_end = (clk_cnt == LAST_CLK);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_Tx_Overflow <= 1'b0;
    end else begin
      o_Tx_Overflow <= i_Tx_DV && !o_Tx_Ready;
      if (push) begin
        mem[wr_ptr] <= i_Tx_Byte;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_n;
      clk_cnt     <= clk_cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      o_Tx_Serial <= serial_n;
      o_Tx_Active <= active_n;
      o_Tx_Done   <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;

    case (state)
      IDLE: begin
        clk_cnt_n = '0;
        bit_idx_n = '0;
        if (count != '0) begin
          shift_n = mem[rd_ptr];
          state_n = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = DATA_BITS;
        end else begin
          clk_cnt_n = clk_cnt + 16'd1;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP_BIT;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 16'd1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          state_n   = CLEANUP;
        end else begin
          clk_cnt_n = clk_cnt + 16'd1;
        end
      end
      CLEANUP: begin
        state_n = IDLE;
      end
      default: begin
        state_n   = IDLE;
        clk_cnt_n = '0;
        bit_idx_n = '0;
      end
    endcase
  end

  // Line outputs are registered, so they are decoded from the next state
  // to line up with the state they describe.
  always_comb begin
    serial_n = 1'b1;
    active_n = 1'b0;
    done_n   = 1'b0;
    case (state_n)
      START_BIT: begin
        serial_n = 1'b0;
        active_n = 1'b1;
      end
      DATA_BITS: begin
        serial_n = shift_n[bit_idx_n];
        active_n = 1'b1;
      end
      STOP_BIT: begin
        active_n = 1'b1;
      end
      CLEANUP: begin
        done_n = 1'b1;
      end
      default: begin
        serial_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a frame-timing model
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int NONE  = -1000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       ready;
  logic       ovf;
  logic [2:0] count;
  logic       serial;
  logic       active;
  logic       done;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Tx_DV      (dv),
    .i_Tx_Byte    (byte_in),
    .o_Tx_Ready   (ready),
    .o_Tx_Overflow(ovf),
    .o_Fifo_Count (count),
    .o_Tx_Serial  (serial),
    .o_Tx_Active  (active),
    .o_Tx_Done    (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: queued bytes, the edge at which the current frame
  // started, and the first edge at which the next frame may start.
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  int         fstart = NONE;
  int         ready_at = 0;
  logic       m_ovf = 1'b0;

  int act_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    int   e;
    int   t;
    int   b;
    logic e_ser;
    logic e_act;
    logic e_done;
    e = cyc + 1;
    if (rst) begin
      q.delete();
      fstart   = NONE;
      ready_at = e + 1;
      m_ovf    = 1'b0;
    end else begin
      logic do_pop;
      logic do_push;
      do_pop  = (e >= ready_at) && (q.size() != 0);
      do_push = dv && (q.size() != DEPTH);
      m_ovf   = dv && (q.size() == DEPTH);
      if (do_pop) begin
        cur      = q.pop_front();
        fstart   = e;
        ready_at = e + FRAME + 2;
      end
      if (do_push) q.push_back(byte_in);
    end
    @(posedge clk);
    cyc = e;
    #1;
    e_ser  = 1'b1;
    e_act  = 1'b0;
    e_done = (e == fstart + FRAME);
    if (e >= fstart && e < fstart + FRAME) begin
      t     = e - fstart;
      b     = t / CPB;
      e_act = 1'b1;
      if (b == 0) e_ser = 1'b0;
      else if (b == 9) e_ser = 1'b1;
      else e_ser = cur[b-1];
    end
    chk("serial", 32'(serial), 32'(e_ser));
    chk("active", 32'(active), 32'(e_act));
    chk("done", 32'(done), 32'(e_done));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("count", 32'(count), 32'(q.size()));
    chk("ready", 32'(ready), 32'(q.size() != DEPTH));
    if (active) act_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic idle(input int n);
    dv = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [7:0] b);
    dv      = 1'b1;
    byte_in = b;
    tick();
    dv      = 1'b0;
    byte_in = $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int j;
    int guard;

    // Reset state, with a write strobe that must be ignored
    rst = 1'b1;
    dv  = 1'b1;
    byte_in = 8'h99;
    tick();
    tick();
    dv  = 1'b0;
    rst = 1'b0;
    idle(3);
    chk("reset_serial", 32'(serial), 32'd1);
    chk("reset_count", 32'(count), 32'd0);

    // Single 0x55 frame
    act_cnt = 0;
    done_cnt = 0;
    write(8'h55);
    idle(FRAME + 6);
    chk("single_active_len", 32'(act_cnt), 32'(FRAME));
    chk("single_done_cnt", 32'(done_cnt), 32'd1);

    // 0x00 then 0xFF back to back
    done_cnt = 0;
    write(8'h00);
    write(8'hFF);
    idle(2 * FRAME + 8);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // Overfill while the first frame is in flight
    write(8'hA0);
    idle(2);
    for (int i = 1; i <= 5; i++) write(8'(8'hA0 + i));
    idle(5 * (FRAME + 2) + 4);

    // Reset in the middle of the data bits of 0x3C
    write(8'h3C);
    write(8'h77);
    idle(CPB + 2 * CPB + 1);
    done_cnt = 0;
    do_reset();
    chk("midreset_serial", 32'(serial), 32'd1);
    chk("midreset_active", 32'(active), 32'd0);
    idle(FRAME + 4);
    chk("midreset_no_done", 32'(done_cnt), 32'd0);

    // Write while full on the same edge as the IDLE pop
    write(8'hB0);
    idle(2);
    for (int i = 1; i <= 4; i++) write(8'(8'hB0 + i));
    guard = 0;
    while (cyc + 1 < ready_at && guard < 200) begin
      tick();
      guard++;
    end
    chk("full_pop_reached", 32'(guard < 200), 32'd1);
    write(8'hEE);
    chk("full_pop_ovf", 32'(ovf), 32'd1);
    chk("full_pop_count", 32'(count), 32'd3);
    idle(4 * (FRAME + 2) + 4);

    // Fill and drain 2*DEPTH+1 incrementing bytes to wrap the pointers
    j = 0;
    guard = 0;
    while ((j < 2 * DEPTH + 1 || q.size() != 0) && guard < 1000) begin
      if (j < 2 * DEPTH + 1 && q.size() != DEPTH) begin
        dv      = 1'b1;
        byte_in = 8'(8'h10 + j);
        j++;
      end else begin
        dv = 1'b0;
      end
      tick();
      guard++;
    end
    dv = 1'b0;
    chk("wrap_all_sent", 32'(j), 32'(2 * DEPTH + 1));
    idle(FRAME + 4);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      dv      = ($urandom_range(0, 9) == 0);
      byte_in = 8'($urandom());
      tick();
    end
    rst = 1'b0;
    dv  = 1'b0;
    guard = 0;
    while ((q.size() != 0 || cyc + 1 < ready_at) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("random_drained", 32'(guard < 1000), 32'd1);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
